forward_unit: RTL and testbench
===============================

FORWARD_UNIT -- requirements
Module: forward_unit

Interface
REQ-001 SHALL provide port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide port: IDValid  input  1  ID-stage slot holds a real instruction.
REQ-004 SHALL provide port: IDOp1  input  4  ID-stage operand-1 register number.
REQ-005 SHALL provide port: IDOp2  input  4  ID-stage operand-2 register number.
REQ-006 SHALL provide port: IDRd  input  4  ID-stage destination register number.
REQ-007 SHALL provide port: IDRegWrite  input  1  ID-stage instruction writes IDRd.
REQ-008 SHALL provide port: IDMulDiv  input  1  ID-stage instruction is multiply/divide (32-bit result: high half to R0, low half to IDRd).
REQ-009 SHALL provide port: IDLoad  input  1  ID-stage instruction is a memory load into IDRd.
REQ-010 SHALL provide port: FlushEX  input  1  branch taken; squash the instruction entering EX.
REQ-011 SHALL provide port: Op1Src  output  2  select for operand-1 forwarding mux (00 reg file, 01 ALU result [31:16], 10 ALU result [15:0], 11 memory read data).
REQ-012 SHALL provide port: Op2Src  output  2  same encoding for operand 2.
REQ-013 SHALL provide port: Stall  output  1  hold PC and IF/ID; insert bubble into EX.
REQ-014 SHALL provide port: StallCount  output  8  saturating count of stall cycles.
REQ-015 SHALL use one clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-016 SHALL keep an EX record {valid, rd, regwrite, muldiv, load} and a MEM record {valid, rd, load} in flops.
REQ-017 SHALL on each clock shift MEM <= EX, and load EX from the ID inputs unless Stall, FlushEX or !IDValid, in which case EX <= bubble (valid=0).
REQ-018 SHALL compute Op1Src, Op2Src and Stall combinationally from the current ID inputs and the EX/MEM records (zero-cycle latency).
REQ-019 SHALL, for each operand independently, select 01 when EX.valid & EX.muldiv & operand==0.
REQ-020 SHALL otherwise select 10 when EX.valid & EX.regwrite & !EX.load & operand==EX.rd.
REQ-021 SHALL otherwise select 11 when MEM.valid & MEM.load & operand==MEM.rd.
REQ-022 SHALL otherwise select 00 (MEM-stage ALU results reach the register file by write-through).
REQ-023 SHALL give EX-stage matches priority over MEM-stage matches; for muldiv with EX.rd==0 the high half (01) wins.
REQ-024 SHALL assert Stall when IDValid & EX.valid & EX.load & (IDOp1==EX.rd | IDOp2==EX.rd); while stalled the selects still reflect REQ-019..022 but the ID instruction is not loaded into EX.
REQ-025 SHALL hold Stall for exactly one cycle per load-use hazard (bubble then MEM-stage forward via 11 on the following cycle).
REQ-026 SHALL, when FlushEX and Stall coincide, give FlushEX priority for the EX record (bubble) and still count the stall cycle.
REQ-027 SHALL force Op1Src, Op2Src to 00 and Stall to 0 when IDValid=0.
REQ-028 SHALL increment StallCount on every clock with Stall=1 and saturate at 255 (no wrap).

Reset
REQ-029 SHALL on rst_n=0 immediately clear EX and MEM valid bits and StallCount to 0, giving Op1Src=00, Op2Src=00, Stall=0.
REQ-030 SHALL, on reset asserted mid-stall, drop Stall within the same cycle and discard any pending hazard; first edge after release operates from empty records.

Verification
REQ-031 SHALL be covered: ADD R3 then SUB R4,R3,R5 back-to-back -> SUB sees Op1Src=10, Op2Src=00, Stall=0.
REQ-032 SHALL be covered: MUL R2 (high to R0) then ADD R6,R0,R2 -> Op1Src=01, Op2Src=10.
REQ-033 SHALL be covered: LOAD R7 then ADD R1,R7,R7 -> cycle 1 Stall=1, StallCount 0->1; cycle 2 Stall=0, Op1Src=Op2Src=11.
REQ-034 SHALL be covered: LOAD R7 with FlushEX=1 on the following cycle, then use of R7 -> no stall, selects 00.
REQ-035 SHALL be covered: 300 consecutive load-use hazards -> StallCount saturates at 255.
REQ-036 SHALL be covered: rst_n pulsed low while Stall=1 -> Stall, selects, StallCount read 0 before next clock edge.

Source files
------------

// File: rtl/forward_if.sv
// ============================================================================
// Module      : forward_if
// Description : ID-stage hazard inputs and forwarding/stall outputs.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface forward_if;
    logic       IDValid;
    logic [3:0] IDOp1;
    logic [3:0] IDOp2;
    logic [3:0] IDRd;
    logic       IDRegWrite;
    logic       IDMulDiv;
    logic       IDLoad;
    logic       FlushEX;
    logic [1:0] Op1Src;
    logic [1:0] Op2Src;
    logic       Stall;
    logic [7:0] StallCount;

    modport master (
        output IDValid, IDOp1, IDOp2, IDRd, IDRegWrite, IDMulDiv, IDLoad, FlushEX,
        input  Op1Src, Op2Src, Stall, StallCount
    );

    modport slave (
        input  IDValid, IDOp1, IDOp2, IDRd, IDRegWrite, IDMulDiv, IDLoad, FlushEX,
        output Op1Src, Op2Src, Stall, StallCount
    );
endinterface

`default_nettype wire

// File: rtl/forward_unit.sv
// ============================================================================
// Module      : forward_unit
// Description : Operand forwarding selects and load-use stall for a 3-stage
//               ID/EX/MEM pipeline, with a saturating stall-cycle counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module forward_unit (
    input  wire logic  clk,
    input  wire logic  rst_n,
    forward_if.slave   fwd
);

    localparam logic [1:0] SRC_REG     = 2'b00;
    localparam logic [1:0] SRC_ALU_HI  = 2'b01;
    localparam logic [1:0] SRC_ALU_LO  = 2'b10;
    localparam logic [1:0] SRC_MEM     = 2'b11;
    localparam logic [7:0] COUNT_MAX   = 8'hFF;

    logic       ex_valid;
    logic [3:0] ex_rd;
    logic       ex_regwrite;
    logic       ex_muldiv;
    logic       ex_load;
    logic       mem_valid;
    logic [3:0] mem_rd;
    logic       mem_load;
    logic [7:0] stall_count;

    logic [1:0] op1_src;
    logic [1:0] op2_src;
    logic       stall;
    logic       ex_bubble;

    // EX results beat MEM results; a muldiv high half targets R0 even if rd==0.
    function automatic logic [1:0] select_src(input logic [3:0] op);
        logic [1:0] src;
        src = SRC_REG;
        if (ex_valid && ex_muldiv && op == 4'd0)
            src = SRC_ALU_HI;
        else if (ex_valid && ex_regwrite && !ex_load && op == ex_rd)
            src = SRC_ALU_LO;
        else if (mem_valid && mem_load && op == mem_rd)
            src = SRC_MEM;
        return src;
    endfunction

    always_comb begin
        op1_src = SRC_REG;
        op2_src = SRC_REG;
        stall   = 1'b0;
        if (fwd.IDValid) begin
            op1_src = select_src(fwd.IDOp1);
            op2_src = select_src(fwd.IDOp2);
            stall   = ex_valid && ex_load &&
                      (fwd.IDOp1 == ex_rd || fwd.IDOp2 == ex_rd);
        end
    end

    assign ex_bubble = stall || fwd.FlushEX || !fwd.IDValid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_rd       <= 4'd0;
            ex_regwrite <= 1'b0;
            ex_muldiv   <= 1'b0;
            ex_load     <= 1'b0;
            mem_valid   <= 1'b0;
            mem_rd      <= 4'd0;
            mem_load    <= 1'b0;
        end else begin
            mem_valid <= ex_valid;
            mem_rd    <= ex_rd;
            mem_load  <= ex_load;
            if (ex_bubble) begin
                ex_valid    <= 1'b0;
                ex_rd       <= 4'd0;
                ex_regwrite <= 1'b0;
                ex_muldiv   <= 1'b0;
                ex_load     <= 1'b0;
            end else begin
                ex_valid    <= 1'b1;
                ex_rd       <= fwd.IDRd;
                ex_regwrite <= fwd.IDRegWrite;
                ex_muldiv   <= fwd.IDMulDiv;
                ex_load     <= fwd.IDLoad;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= 8'd0;
        else if (stall && stall_count != COUNT_MAX)
            stall_count <= stall_count + 8'd1;
    end

    assign fwd.Op1Src     = op1_src;
    assign fwd.Op2Src     = op2_src;
    assign fwd.Stall      = stall;
    assign fwd.StallCount = stall_count;

endmodule

`default_nettype wire

// File: tb/tb_forward_unit.sv
// ============================================================================
// Module      : tb_forward_unit
// Description : Directed-vector self-checking bench for forward_unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_forward_unit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   exp_cnt;

    forward_if fif ();

    forward_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fwd   (fif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one ID-stage instruction just after a falling edge.
    task automatic set_id(input logic v, input logic [3:0] o1, input logic [3:0] o2,
                          input logic [3:0] rd, input logic rw, input logic md,
                          input logic ld, input logic fl);
        fif.IDValid    = v;
        fif.IDOp1      = o1;
        fif.IDOp2      = o2;
        fif.IDRd       = rd;
        fif.IDRegWrite = rw;
        fif.IDMulDiv   = md;
        fif.IDLoad     = ld;
        fif.FlushEX    = fl;
        #1;
    endtask

    task automatic step();
        if (fif.Stall && exp_cnt < 255) exp_cnt++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [1:0] s1, input logic [1:0] s2,
                           input logic st);
        chk({tag, ".op1"}, {30'd0, fif.Op1Src}, {30'd0, s1});
        chk({tag, ".op2"}, {30'd0, fif.Op2Src}, {30'd0, s2});
        chk({tag, ".stall"}, {31'd0, fif.Stall}, {31'd0, st});
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        exp_cnt = 0;
        rst_n   = 1'b0;
        set_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk_out("reset", 2'b00, 2'b00, 1'b0);
        chk("reset.cnt", {24'd0, fif.StallCount}, 32'd0);
        rst_n = 1'b1;

        // ADD R3 ; SUB R4,R3,R5
        set_id(1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("add_empty", 2'b00, 2'b00, 1'b0);
        step();
        set_id(1'b1, 4'd3, 4'd5, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("sub_fwd", 2'b10, 2'b00, 1'b0);
        step();

        // MUL R2 ; ADD R6,R0,R2
        set_id(1'b1, 4'd8, 4'd9, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_out("mul_nomatch", 2'b00, 2'b00, 1'b0);
        step();
        set_id(1'b1, 4'd0, 4'd2, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("muldiv_fwd", 2'b01, 2'b10, 1'b0);
        step();

        // LOAD R7 ; ADD R1,R7,R7
        set_id(1'b1, 4'd1, 4'd1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_out("load_issue", 2'b00, 2'b00, 1'b0);
        step();
        set_id(1'b1, 4'd7, 4'd7, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("loaduse_c1", 2'b00, 2'b00, 1'b1);
        chk("loaduse_c1.cnt", {24'd0, fif.StallCount}, 32'd0);
        step();
        chk_out("loaduse_c2", 2'b11, 2'b11, 1'b0);
        chk("loaduse_c2.cnt", {24'd0, fif.StallCount}, 32'd1);
        step();

        // LOAD R7 squashed by FlushEX, then use of R7
        set_id(1'b1, 4'd5, 4'd5, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        chk_out("flushed_load", 2'b00, 2'b00, 1'b0);
        step();
        set_id(1'b1, 4'd7, 4'd7, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("after_flush", 2'b00, 2'b00, 1'b0);
        step();

        // IDValid low masks a live hazard; then FlushEX coinciding with stall
        set_id(1'b1, 4'd5, 4'd5, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        set_id(1'b0, 4'd7, 4'd7, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("idvalid_low", 2'b00, 2'b00, 1'b0);
        set_id(1'b1, 4'd7, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_out("flush_stall", 2'b00, 2'b00, 1'b1);
        step();
        chk("flush_stall.cnt", {24'd0, fif.StallCount}, exp_cnt);
        // EX is a bubble; MEM holds the load, so R7 now comes from memory data
        set_id(1'b1, 4'd7, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("flush_stall_nxt", 2'b11, 2'b00, 1'b0);
        step();

        // 300 load-use hazards
        for (int i = 0; i < 300; i++) begin
            set_id(1'b1, 4'd5, 4'd5, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
            step();
            set_id(1'b1, 4'd7, 4'd5, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("sat.stall", {31'd0, fif.Stall}, 32'd1);
            step();
            step();
        end
        chk("sat.cnt", {24'd0, fif.StallCount}, 32'd255);
        chk("sat.model", exp_cnt, 32'd255);

        // Reset pulsed mid-stall
        set_id(1'b1, 4'd5, 4'd5, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        set_id(1'b1, 4'd7, 4'd7, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_pre.stall", {31'd0, fif.Stall}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_out("rst_mid", 2'b00, 2'b00, 1'b0);
        chk("rst_mid.cnt", {24'd0, fif.StallCount}, 32'd0);
        rst_n = 1'b1;
        exp_cnt = 0;
        step();
        chk("rst_after.cnt", {24'd0, fif.StallCount}, 32'd0);
        // ADD R1 was accepted from empty records and now forwards from EX
        set_id(1'b1, 4'd1, 4'd3, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("rst_after", 2'b10, 2'b00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
